pixel_serializer: RTL and testbench

Streaming source for the binary-image pipeline. It unpacks 16-bit words of 1-bit pixels, received over a valid/ready handshake, into the one-pixel-per-clock `write`/`pixel` stream that the blob and corner stages consume. Frame geometry is taken from run-time `width`/`height` inputs. The block tags each pixel with its coordinate so that downstream debug and overlay logic can share it. It sits between the frame-memory reader (or a test stimulus DMA) and the corner detector.

---
 rtl/pixel_stream_pkg.sv | 15 +
 rtl/frame_coord_counter.sv | 38 +++
 rtl/pixel_serializer.sv | 153 +++++++++++++++
 tb/tb_pixel_serializer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the binary-image streaming stages: default widths,
// coordinate type and frame-state encoding.
package pixel_stream_pkg;

  localparam int DEF_WORD_W  = 16;
  localparam int DEF_COORD_W = 16;

  typedef logic [DEF_COORD_W-1:0] coord_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } frame_state_t;

endpackage

// File: rtl/frame_coord_counter.sv
// Raster x/y counter: advances one pixel per 'advance', wraps x at width-1,
// and flags the last pixel of the frame. Shared with the corner stage.
module frame_coord_counter
  import pixel_stream_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               advance,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  logic row_last;

  assign row_last = (x == width - COORD_W'(1));
  assign last     = row_last && (y == height - COORD_W'(1));

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (row_last) begin
        x <= '0;
        y <= y + COORD_W'(1);
      end else begin
        x <= x + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_serializer.sv
// Unpacks WORD_W-pixel words into a one-pixel-per-clock tagged raster stream.
// Optional frame markers out_sof/out_eof exist when PIXEL_SERIALIZER_MARKERS_EN is defined.
module pixel_serializer
  import pixel_stream_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  input  logic               in_write,
  input  logic [WORD_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_write,
  output logic               out_pixel,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y
`ifdef PIXEL_SERIALIZER_MARKERS_EN
  ,
  output logic               out_sof,
  output logic               out_eof
`endif
);

  localparam int CNT_W = $clog2(WORD_W) + 1;

  frame_state_t       state;
  logic [WORD_W-1:0]  sh;
  logic [WORD_W-1:0]  hold;
  logic               hold_v;
  logic [CNT_W-1:0]   cnt;
  logic [COORD_W-1:0] w_lat;
  logic [COORD_W-1:0] h_lat;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               last;
  logic               accept;
  logic               emit;
  logic               frame_end;
  logic               start;
  logic               empties;

  assign in_ready  = !hold_v;
  assign accept    = in_write && in_ready;
  assign emit      = (state == RUN) && (cnt != '0);
  assign frame_end = emit && last;
  // A zero dimension keeps the block idle; words pile up in hold only.
  assign start     = (state == IDLE) && (width != '0) && (height != '0) && (hold_v || accept);
  assign empties   = (cnt == '0) || (emit && cnt == CNT_W'(1));

  frame_coord_counter #(
    .COORD_W(COORD_W)
  ) u_coord (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (start || frame_end),
    .advance(emit),
    .width  (w_lat),
    .height (h_lat),
    .x      (x),
    .y      (y),
    .last   (last)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      sh        <= '0;
      hold      <= '0;
      hold_v    <= 1'b0;
      cnt       <= '0;
      w_lat     <= '0;
      h_lat     <= '0;
      out_write <= 1'b0;
      out_pixel <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_write <= emit;
      out_pixel <= emit ? sh[0] : 1'b0;
      out_x     <= x;
      out_y     <= y;

      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            w_lat <= width;
            h_lat <= height;
            cnt   <= CNT_W'(WORD_W);
            if (hold_v) begin
              sh     <= hold;
              hold_v <= 1'b0;
            end else begin
              sh <= in_data;
            end
          end else if (accept) begin
            hold   <= in_data;
            hold_v <= 1'b1;
          end
        end

        RUN: begin
          if (frame_end) begin
            // Residue bits are dropped; the next frame begins on a fresh word.
            state <= IDLE;
            cnt   <= '0;
            if (accept) begin
              hold   <= in_data;
              hold_v <= 1'b1;
            end
          end else if (empties) begin
            if (hold_v) begin
              sh     <= hold;
              cnt    <= CNT_W'(WORD_W);
              hold_v <= 1'b0;
            end else if (accept) begin
              sh  <= in_data;
              cnt <= CNT_W'(WORD_W);
            end else if (emit) begin
              sh  <= sh >> 1;
              cnt <= cnt - CNT_W'(1);
            end
          end else begin
            sh  <= sh >> 1;
            cnt <= cnt - CNT_W'(1);
            if (accept) begin
              hold   <= in_data;
              hold_v <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIXEL_SERIALIZER_MARKERS_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_sof <= 1'b0;
      out_eof <= 1'b0;
    end else begin
      out_sof <= emit && (x == '0) && (y == '0);
      out_eof <= frame_end;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_serializer.sv
// Scoreboard bench for pixel_serializer: stimulus pushes expected pixels,
// a negedge monitor pops and compares every out_write cycle.
module tb_pixel_serializer;
  import pixel_stream_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] width = 16'd0;
  logic [15:0] height = 16'd0;
  logic        in_write = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        in_ready;
  logic        out_write;
  logic        out_pixel;
  logic [15:0] out_x;
  logic [15:0] out_y;
`ifdef PIXEL_SERIALIZER_MARKERS_EN
  logic        out_sof;
  logic        out_eof;
`endif

  pixel_serializer #(.WORD_W(16), .COORD_W(16)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .width    (width),
    .height   (height),
    .in_write (in_write),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_write(out_write),
    .out_pixel(out_pixel),
    .out_x    (out_x),
    .out_y    (out_y)
`ifdef PIXEL_SERIALIZER_MARKERS_EN
    ,
    .out_sof  (out_sof),
    .out_eof  (out_eof)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic   pix;
    coord_t x;
    coord_t y;
    logic   sof;
    logic   eof;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  int     npix = 0;
  int     run_len = 0;
  int     max_run = 0;
  logic   saw_not_ready = 1'b0;
  coord_t mx = '0;
  coord_t my = '0;
  coord_t mw = '0;
  coord_t mh = '0;

  // Monitor: every output pixel must match the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (out_write) begin
      npix++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got pixel=%0d at (%0d,%0d) required no write",
                 out_pixel, out_x, out_y);
      end else begin
        e = sb.pop_front();
        if ({out_pixel, out_x, out_y} !== {e.pix, e.x, e.y}) begin
          errors++;
          $display("FAIL pixel got %0d@(%0d,%0d) required %0d@(%0d,%0d)",
                   out_pixel, out_x, out_y, e.pix, e.x, e.y);
        end
`ifdef PIXEL_SERIALIZER_MARKERS_EN
        checks++;
        if ({out_sof, out_eof} !== {e.sof, e.eof}) begin
          errors++;
          $display("FAIL markers at (%0d,%0d) got sof=%0d eof=%0d required sof=%0d eof=%0d",
                   e.x, e.y, out_sof, out_eof, e.sof, e.eof);
        end
`endif
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  // Reference raster: push the pixels a word should produce, dropping residue at frame end.
  task automatic model_word(input logic [15:0] d);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.pix = d[i];
      e.x   = mx;
      e.y   = my;
      e.sof = (mx == 0) && (my == 0);
      e.eof = (mx == mw - 1) && (my == mh - 1);
      sb.push_back(e);
      if (e.eof) begin
        mx = '0;
        my = '0;
        break;
      end
      if (mx == mw - 1) begin
        mx = '0;
        my = my + 1;
      end else begin
        mx = mx + 1;
      end
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input logic [15:0] d);
    int t = 0;
    if (!in_ready) saw_not_ready = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready got 0 required 1");
    end
    in_write = 1'b1;
    in_data  = d;
    @(negedge clock);
    in_write = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int t = 0;
    while (sb.size() != 0 && t < limit) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending got %0d required 0", sb.size());
      sb.delete();
    end
    repeat (8) @(negedge clock);
  endtask

  task automatic set_geom(input logic [15:0] w, input logic [15:0] h);
    width  = w;
    height = h;
    mw     = w;
    mh     = h;
  endtask

  initial begin
    int t;
    int base;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("reset_out_write", 32'(out_write), 32'd0);
    check("reset_out_pixel", 32'(out_pixel), 32'd0);
    check("reset_out_xy", 32'({out_x, out_y}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // 4x2 frame from one word; upper byte is residue.
    set_geom(16'd4, 16'd2);
    model_word(16'hA5C3);
    send(16'hA5C3);
    wait_drain(100);

    // 20x1 with a starved gap after the first word.
    set_geom(16'd20, 16'd1);
    model_word(16'h3C5A);
    send(16'h3C5A);
    repeat (20) @(negedge clock);
    check("gap_out_write", 32'(out_write), 32'd0);
    check("gap_out_x", 32'(out_x), 32'd16);
    model_word(16'hFFF9);
    send(16'hFFF9);
    wait_drain(100);

    // Two back-to-back 8x1 frames.
    set_geom(16'd8, 16'd1);
    model_word(16'hFF96);
    send(16'hFF96);
    model_word(16'h00E1);
    send(16'h00E1);
    wait_drain(100);

    // Zero width: one word is held, nothing is emitted, ready stays low.
    set_geom(16'd0, 16'd2);
    send(16'hFFFF);
    check("zero_width_in_ready", 32'(in_ready), 32'd0);
    repeat (40) @(negedge clock);
    check("zero_width_in_ready_late", 32'(in_ready), 32'd0);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("after_reset_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a 320x240 frame.
    set_geom(16'd320, 16'd240);
    base = npix;
    for (int i = 0; i < 7; i++) begin
      model_word(16'(i * 16'h1357 + 16'h0F0F));
      send(16'(i * 16'h1357 + 16'h0F0F));
    end
    t = 0;
    while (npix - base < 100 && t < 500) begin
      @(posedge clock);
      t++;
    end
    check("midframe_reached_100", 32'(npix - base >= 100), 32'd1);
    #1 reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("midreset_out_write", 32'(out_write), 32'd0);
    check("midreset_out_pixel", 32'(out_pixel), 32'd0);
    check("midreset_out_xy", 32'({out_x, out_y}), 32'd0);
`ifdef PIXEL_SERIALIZER_MARKERS_EN
    check("midreset_markers", 32'({out_sof, out_eof}), 32'd0);
`endif
    sb.delete();
    mx = '0;
    my = '0;
    @(negedge clock);
    reset_n = 1'b1;
    set_geom(16'd4, 16'd1);
    model_word(16'h0006);
    send(16'h0006);
    wait_drain(100);

    // Full 320x240 frame, words back-to-back: must be one unbroken run.
    set_geom(16'd320, 16'd240);
    saw_not_ready = 1'b0;
    max_run = 0;
    for (int i = 0; i < 4800; i++) begin
      model_word(16'(i * 40503 + 7));
      send(16'(i * 40503 + 7));
    end
    wait_drain(300);
    check("full_frame_contiguous", 32'(max_run), 32'd76800);
    check("full_frame_ready_toggled", 32'(saw_not_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
